// File: rtl/dds_pkg.sv
// Shared DDS definitions: SPI DAC frame geometry, default DAC header and
// the serialiser FSM state encoding.
package dds_pkg;

   localparam int FRAME_BITS = 16;
   localparam int HALF_PERIODS = 2 * FRAME_BITS;
   localparam logic [3:0] DAC_HDR_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } dac_state_t;

endpackage

// File: rtl/dac_spi_tx_clk_en.sv
// spi_clk_en: divides clk by DIV and produces a one-cycle tick at the end of
// every sclk half-period. Held cleared while clr is high so each frame starts
// with a fresh, full-length first half-period.
module spi_clk_en #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-DIV counter, restarted whenever clr is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises each accepted M-bit sample as a 16-bit frame
// {HEADER, sample} to an MCP4921-style DAC, SPI mode 0, MSB first.
// Optional macro DAC_SPI_LDAC_EN adds an ldac_n strobe after each frame.
//
// Handshake: a sample is taken on a rising clk edge where sample_valid and
// sample_ready are both high; sample_ready is high only while the FSM is IDLE,
// so the source may hold sample_valid high and present samples at any rate.
import dds_pkg::*;

module dac_spi_tx #(
   parameter int M = 12,
   parameter int HDR_W = 4,
   parameter logic [HDR_W-1:0] HEADER = DAC_HDR_DEFAULT,
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [M-1:0] sample,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic         sclk,
   output logic         mosi,
   output logic         cs_n,
   output logic         busy
`ifdef DAC_SPI_LDAC_EN
   ,
   output logic         ldac_n
`endif
);

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("dac_spi_tx: CLK_DIV must be at least 1");
      end
      if (M + HDR_W != FRAME_BITS) begin : g_bad_width
         $error("dac_spi_tx: M + HDR_W must equal FRAME_BITS");
      end
   endgenerate

   localparam logic [4:0] LAST_HALF = 5'(HALF_PERIODS - 1);

   dac_state_t state;
   logic [4:0] half_cnt;
   // Bits still to be sent after the one currently on mosi.
   logic [FRAME_BITS-2:0] shreg;
   logic [FRAME_BITS-1:0] load_frame;
   logic tick;
   logic clk_clr;
`ifdef DAC_SPI_LDAC_EN
   logic ldac_phase;
`endif

   assign load_frame = {HEADER, sample};
   assign clk_clr = (state == ST_IDLE);

   spi_clk_en #(
      .DIV(CLK_DIV)
   ) u_clk_en (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clk_clr),
      .tick (tick)
   );

   // Frame FSM: all SPI pins and handshake outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         sample_ready <= 1'b1;
         busy         <= 1'b0;
         cs_n         <= 1'b1;
         sclk         <= 1'b0;
         mosi         <= 1'b0;
         shreg        <= '0;
         half_cnt     <= '0;
`ifdef DAC_SPI_LDAC_EN
         ldac_n       <= 1'b1;
         ldac_phase   <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (sample_valid && sample_ready) begin
                  state        <= ST_SHIFT;
                  sample_ready <= 1'b0;
                  busy         <= 1'b1;
                  cs_n         <= 1'b0;
                  sclk         <= 1'b0;
                  mosi         <= load_frame[FRAME_BITS-1];
                  shreg        <= load_frame[FRAME_BITS-2:0];
                  half_cnt     <= '0;
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (half_cnt == LAST_HALF) begin
                     // Final falling edge: close the frame, no further shift.
                     state <= ST_HOLD;
                     sclk  <= 1'b0;
                     cs_n  <= 1'b1;
                     mosi  <= 1'b0;
                  end else begin
                     half_cnt <= half_cnt + 5'd1;
                     sclk     <= ~sclk;
                     if (sclk) begin
                        mosi  <= shreg[FRAME_BITS-2];
                        shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
`ifdef DAC_SPI_LDAC_EN
                  if (!ldac_phase) begin
                     ldac_phase <= 1'b1;
                     ldac_n     <= 1'b0;
                  end else begin
                     ldac_phase   <= 1'b0;
                     ldac_n       <= 1'b1;
                     state        <= ST_IDLE;
                     sample_ready <= 1'b1;
                     busy         <= 1'b0;
                  end
`else
                  state        <= ST_IDLE;
                  sample_ready <= 1'b1;
                  busy         <= 1'b0;
`endif
               end
            end
            default: begin
               state        <= ST_IDLE;
               sample_ready <= 1'b1;
               busy         <= 1'b0;
               cs_n         <= 1'b1;
               sclk         <= 1'b0;
               mosi         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: drives samples through the valid/ready handshake,
// decodes the SPI pins back into frames and checks content and timing.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
   localparam int C = 1;
   localparam int HOLD_CYC = 2 * C;
`else
   localparam int C = 4;
   localparam int HOLD_CYC = C;
`endif
   localparam int READY_REL = 32 * C + HOLD_CYC + 1;
   localparam int GAP = HOLD_CYC + 1;
   localparam int BUDGET = 40 * C + 60;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [11:0] sample = '0;
   logic sample_valid = 1'b0;
   logic sample_ready, sclk, mosi, cs_n, busy;
`ifdef DAC_SPI_LDAC_EN
   logic ldac_n;
`endif

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0 = 0;

   logic [15:0] exp_q[$];
   int gap_q[$];

   dac_spi_tx #(.CLK_DIV(C)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample(sample),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sclk(sclk),
      .mosi(mosi),
      .cs_n(cs_n),
      .busy(busy)
`ifdef DAC_SPI_LDAC_EN
      ,
      .ldac_n(ldac_n)
`endif
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SPI monitor + scoreboard: rebuild each frame from mosi at sclk rises
   logic prev_cs = 1'b1;
   logic prev_sclk = 1'b0;
   bit in_frame = 0;
   logic [15:0] cur = '0;
   logic [15:0] last_frame = '0;
   int rises = 0, low_len = 0, hi_run = 0, frames_done = 0;
   int last_rises = 0, last_low = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 0;
         prev_cs = 1'b1;
         prev_sclk = 1'b0;
         hi_run = 0;
      end else begin
         if (cs_n === 1'b0) begin
            if (prev_cs) begin
               in_frame = 1;
               rises = 0;
               low_len = 0;
               cur = '0;
               gap_q.push_back(hi_run);
               hi_run = 0;
            end
            low_len++;
            if (sclk && !prev_sclk) begin
               cur = {cur[14:0], mosi};
               rises++;
            end
         end else begin
            hi_run++;
            n_tests++;
            if (sclk !== 1'b0) begin
               n_fail++;
               $display("FAIL sclk_while_cs_high: sclk=%b required 0 at cycle %0d", sclk, cyc);
            end
            if (!prev_cs && in_frame) begin
               in_frame = 0;
               frames_done++;
               last_frame = cur;
               last_rises = rises;
               last_low = low_len;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_frame: got %h with nothing expected", cur);
               end else begin
                  logic [15:0] e;
                  e = exp_q.pop_front();
                  if (cur !== e) begin
                     n_fail++;
                     $display("FAIL frame_data: got %h required %h", cur, e);
                  end
               end
               n_tests++;
               if (rises !== 16) begin
                  n_fail++;
                  $display("FAIL sclk_rises: got %0d required 16", rises);
               end
               n_tests++;
               if (low_len !== 32 * C) begin
                  n_fail++;
                  $display("FAIL cs_low_len: got %0d required %0d", low_len, 32 * C);
               end
            end
         end
         prev_cs = cs_n;
         prev_sclk = sclk;
      end
   end

   // driver: present s, wait for the handshake, record the expected frame
   task automatic send(input logic [11:0] s, input bit keep_valid);
      int n;
      n = 0;
      sample_valid = 1'b1;
      sample = s;
      while (sample_ready !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: ready=%b required 1", sample_ready);
      end
      exp_q.push_back({4'b0011, s});
      @(posedge clk);
      #1;
      t0 = cyc;
      if (!keep_valid) sample_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(sample_ready === 1'b1 && cs_n === 1'b1) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n >= BUDGET) begin
         n_fail++;
         $display("FAIL idle_timeout: ready=%b cs_n=%b required 1/1", sample_ready, cs_n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cs_n, sclk, mosi, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_outputs: cs_n,sclk,mosi,busy=%b required 1000", {cs_n, sclk, mosi, busy});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (sample_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b required 1/0", sample_ready, busy);
      end
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n_tests++;
         if ({cs_n, sclk, mosi, sample_ready, busy} !== 5'b10010) begin
            n_fail++;
            bad++;
            if (bad < 4)
               $display("FAIL idle_outputs: cs_n,sclk,mosi,ready,busy=%b required 10010", {cs_n, sclk, mosi, sample_ready, busy});
         end
      end
   endtask

   task automatic test_single();
      int n, start_frames;
      start_frames = frames_done;
      send(12'hA5C, 0);
      n = 0;
      @(negedge clk);
      while (sample_ready !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (cyc - t0 + 1 !== READY_REL) begin
         n_fail++;
         $display("FAIL ready_return: cycle T0+%0d required T0+%0d", cyc - t0 + 1, READY_REL);
      end
      n_tests++;
      if (frames_done - start_frames !== 1 || last_frame !== 16'h3A5C) begin
         n_fail++;
         $display("FAIL single_frame: frames=%0d data=%h required 1 / 3a5c", frames_done - start_frames, last_frame);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] vals[3];
      vals[0] = 12'h000;
      vals[1] = 12'hFFF;
      vals[2] = 12'h800;
      gap_q.delete();
      for (int i = 0; i < 3; i++) send(vals[i], i < 2);
      wait_idle();
      n_tests++;
      if (gap_q.size() !== 3) begin
         n_fail++;
         $display("FAIL b2b_frames: got %0d frame starts required 3", gap_q.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_tests++;
            if (gap_q[i] !== GAP) begin
               n_fail++;
               $display("FAIL b2b_gap: got %0d cycles required %0d", gap_q[i], GAP);
            end
         end
      end
      n_tests++;
      if (last_frame !== 16'h3800) begin
         n_fail++;
         $display("FAIL b2b_last: got %h required 3800", last_frame);
      end
   endtask

   task automatic test_mid_change();
      send(12'h123, 0);
      repeat (10 * C - 1) @(posedge clk);
      #1 sample = 12'h456;
      wait_idle();
      n_tests++;
      if (last_frame !== 16'h3123) begin
         n_fail++;
         $display("FAIL mid_change: got %h required 3123", last_frame);
      end
   endtask

   task automatic test_async_reset();
      int fr;
      logic [11:0] s;
      send(12'h3C7, 0);
      repeat (12 * C + 1) @(posedge clk);
      #1;
      n_tests++;
      if (cs_n !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_cs: cs_n=%b required 0", cs_n);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: cs_n=%b sclk=%b busy=%b required 1/0/0", cs_n, sclk, busy);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fr = frames_done;
      repeat (50) @(negedge clk);
      n_tests++;
      if (frames_done !== fr || cs_n !== 1'b1 || sample_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL no_replay: frames=%0d cs_n=%b ready=%b required %0d/1/1", frames_done, cs_n, sample_ready, fr);
      end
      s = 12'($urandom_range(0, 4095));
      send(s, 0);
      wait_idle();
      n_tests++;
      if (last_frame !== {4'b0011, s}) begin
         n_fail++;
         $display("FAIL post_reset_frame: got %h required %h", last_frame, {4'b0011, s});
      end
   endtask

   task automatic test_random();
      int fr;
      fr = frames_done;
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         send(12'($urandom_range(0, 4095)), 0);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 20 * C)) @(posedge clk);
            #1 sample = 12'($urandom_range(0, 4095));
         end
      end
      wait_idle();
      n_tests++;
      if (frames_done - fr !== 16 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL random_frames: got %0d frames, %0d pending required 16/0", frames_done - fr, exp_q.size());
      end
   endtask

`ifdef DAC_SPI_LDAC_EN
   task automatic test_ldac();
      int cs_rel, low_rel, low_cnt, rdy_rel, rel;
      cs_rel = -1;
      low_rel = -1;
      low_cnt = 0;
      rdy_rel = -1;
      send(12'h5A5, 0);
      for (int i = 0; i < BUDGET && rdy_rel < 0; i++) begin
         @(negedge clk);
         rel = cyc - t0 + 1;
         if (cs_n === 1'b1 && cs_rel < 0) cs_rel = rel;
         if (ldac_n === 1'b0) begin
            if (low_rel < 0) low_rel = rel;
            low_cnt++;
         end
         if (sample_ready === 1'b1) rdy_rel = rel;
      end
      n_tests++;
      if (low_cnt !== C || low_rel !== cs_rel + C) begin
         n_fail++;
         $display("FAIL ldac_pulse: %0d cycles at T0+%0d (cs rise T0+%0d) required %0d at cs+%0d", low_cnt, low_rel, cs_rel, C, C);
      end
      n_tests++;
      if (rdy_rel !== READY_REL) begin
         n_fail++;
         $display("FAIL ldac_ready: T0+%0d required T0+%0d", rdy_rel, READY_REL);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_mid_change();
      test_async_reset();
      test_random();
`ifdef DAC_SPI_LDAC_EN
      test_ldac();
`endif
      repeat (5) @(negedge clk);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL pending_frames: %0d left required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
